restoring_divider: RTL

- Sequential unsigned N-bit integer divider built on a shift/trial-subtract loop.
- It is the inverse operation of the adder/multiplier datapath. Each iteration uses a ripple borrow chain, the subtractor form of the full-adder carry chain.
- Produces one quotient bit per clock, with a start/busy/done handshake, and sits beside the multiplier in the arithmetic section.

---
 rtl/restoring_divider.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned N-bit restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged without iterating.
module restoring_divider #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div0
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ripple-borrow subtractor over N+1 bits; returns {borrow_out, difference}.
    function automatic logic [N+1:0] trial_sub(input logic [N:0] minuend,
                                               input logic [N-1:0] subtrahend);
        logic [N:0] sub_ext;
        logic [N:0] diff;
        logic       borrow;
        sub_ext = {1'b0, subtrahend};
        diff    = {(N+1){1'b0}};
        borrow  = 1'b0;
        for (int i = 0; i <= N; i++) begin
            diff[i] = minuend[i] ^ sub_ext[i] ^ borrow;
            borrow  = (~minuend[i] & sub_ext[i]) | (~(minuend[i] ^ sub_ext[i]) & borrow);
        end
        return {borrow, diff};
    endfunction

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [N-1:0]   dvd_r, dvd_s;
    logic [N-1:0]   dvs_r, dvs_s;
    logic [N:0]     rem_r, rem_s;
    logic [N-1:0]   quo_r, quo_s;
    logic [N-1:0]   q_r, q_s;
    logic [N-1:0]   r_r, r_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic           div0_r, div0_s;

    logic [N:0]     rem_shift_s;
    logic [N+1:0]   trial_s;
    logic           qbit_s;
    logic [N:0]     rem_iter_s;
    logic [N-1:0]   quo_iter_s;

    // Single iteration datapath: shift in dividend MSB, trial subtract, restore on borrow.
    always_comb begin
        rem_shift_s = (rem_r << 1) | {{N{1'b0}}, dvd_r[N-1]};
        trial_s     = trial_sub(rem_shift_s, dvs_r);
        qbit_s      = ~trial_s[N+1];
        rem_iter_s  = qbit_s ? trial_s[N:0] : rem_shift_s;
        quo_iter_s  = (quo_r << 1) | {{(N-1){1'b0}}, qbit_s};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dvd_s   = dvd_r;
        dvs_s   = dvs_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        q_s     = q_r;
        r_s     = r_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        div0_s  = div0_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (B == {N{1'b0}}) begin
                        // Divide by zero completes immediately with all-ones quotient.
                        done_s = 1'b1;
                        div0_s = 1'b1;
                        q_s    = {N{1'b1}};
                        r_s    = A;
                        busy_s = 1'b0;
                    end else begin
                        state_s = RUN;
                        dvd_s   = A;
                        dvs_s   = B;
                        rem_s   = {(N+1){1'b0}};
                        quo_s   = {N{1'b0}};
                        cnt_s   = CW'(N - 1);
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                rem_s = rem_iter_s;
                dvd_s = dvd_r << 1;
                quo_s = quo_iter_s;
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    div0_s  = 1'b0;
                    q_s     = quo_iter_s;
                    r_s     = rem_iter_s[N-1:0];
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            dvd_r   <= {N{1'b0}};
            dvs_r   <= {N{1'b0}};
            rem_r   <= {(N+1){1'b0}};
            quo_r   <= {N{1'b0}};
            q_r     <= {N{1'b0}};
            r_r     <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dvd_r   <= dvd_s;
            dvs_r   <= dvs_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            q_r     <= q_s;
            r_r     <= r_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            div0_r  <= div0_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Q    = q_r;
    assign R    = r_r;
    assign div0 = div0_r;

endmodule
